// File: rtl/lut_neuron_pkg.sv
// Shared types and sizing helpers for the runtime-loadable neuron LUT.
package lut_neuron_pkg;

    // Default neuron fan-in width and output activation width
    localparam int DEF_IN_BITS  = 4;
    localparam int DEF_OUT_BITS = 2;

    // Loader states: no table, table being streamed in, table usable
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2
    } state_e;

    // Number of table entries addressed by an in_bits-wide address
    function automatic int table_depth(input int in_bits);
        return 1 << in_bits;
    endfunction

endpackage

// File: rtl/lut_neuron_table_mem.sv
// Truth-table storage: register array with one write port and one registered
// read port. The array itself is not reset; only the read register is.
// Optional macro LUT_READBACK_EN adds an asynchronous host readback port.
module lut_neuron_table_mem
    import lut_neuron_pkg::*;
#(
    parameter int IN_BITS  = DEF_IN_BITS,
    parameter int OUT_BITS = DEF_OUT_BITS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en_i,
    input  logic [IN_BITS-1:0]  wr_addr_i,
    input  logic [OUT_BITS-1:0] wr_data_i,
    input  logic                rd_en_i,
    input  logic [IN_BITS-1:0]  rd_addr_i,
    output logic [OUT_BITS-1:0] rd_data_o
`ifdef LUT_READBACK_EN
    ,
    input  logic [IN_BITS-1:0]  rb_addr_i,
    output logic [OUT_BITS-1:0] rb_data_o
`endif
);

    localparam int DEPTH = table_depth(IN_BITS);

    logic [OUT_BITS-1:0] mem_q [DEPTH];
    logic [OUT_BITS-1:0] rd_data_q;

    // Table write: contents survive reset and must be reloaded by the host
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Registered lookup; holds the last result when no request is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

`ifdef LUT_READBACK_EN
    assign rb_data_o = mem_q[rb_addr_i];
`endif

endmodule

// File: rtl/lut_neuron_table_loader.sv
// Runtime-programmable neuron LUT: streams a truth table in address order over
// a valid/ready config port, then serves 1-cycle-latency lookups.
// Optional macro LUT_READBACK_EN adds rb_addr/rb_data for host readback.
module lut_neuron_table_loader
    import lut_neuron_pkg::*;
#(
    parameter int IN_BITS  = DEF_IN_BITS,
    parameter int OUT_BITS = DEF_OUT_BITS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load_start,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [OUT_BITS-1:0] cfg_data,
    output logic                load_done,
    output logic                table_valid,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IN_BITS-1:0]  in_data,
    output logic                out_valid,
    output logic [OUT_BITS-1:0] out_data
`ifdef LUT_READBACK_EN
    ,
    input  logic [IN_BITS-1:0]  rb_addr,
    output logic [OUT_BITS-1:0] rb_data
`endif
);

    localparam logic [IN_BITS-1:0] LAST_ADDR = '1;

    state_e               state_q;
    logic [IN_BITS-1:0]   wr_addr_q;
    logic                 cfg_ready_q;
    logic                 load_done_q;
    logic                 table_valid_q;
    logic                 in_ready_q;
    logic                 out_valid_q;

    logic                 cfg_hs_d;
    logic                 wr_en_d;
    logic                 rd_en_d;

    // Config handshake; a simultaneous load_start restart discards the entry
    always_comb begin
        cfg_hs_d = cfg_valid && cfg_ready_q;
        wr_en_d  = cfg_hs_d && !load_start;
        rd_en_d  = in_valid && in_ready_q;
    end

    // Loader FSM with registered control outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= EMPTY;
            wr_addr_q     <= '0;
            cfg_ready_q   <= 1'b0;
            load_done_q   <= 1'b0;
            table_valid_q <= 1'b0;
            in_ready_q    <= 1'b0;
        end else begin
            load_done_q <= 1'b0;
            case (state_q)
                EMPTY: begin
                    if (load_start) begin
                        state_q     <= LOAD;
                        wr_addr_q   <= '0;
                        cfg_ready_q <= 1'b1;
                    end
                end
                LOAD: begin
                    if (load_start) begin
                        wr_addr_q <= '0;
                    end else if (cfg_hs_d) begin
                        if (wr_addr_q == LAST_ADDR) begin
                            wr_addr_q     <= '0;
                            load_done_q   <= 1'b1;
                            state_q       <= READY;
                            cfg_ready_q   <= 1'b0;
                            table_valid_q <= 1'b1;
                            in_ready_q    <= 1'b1;
                        end else begin
                            wr_addr_q <= wr_addr_q + 1'b1;
                        end
                    end
                end
                READY: begin
                    if (load_start) begin
                        state_q       <= LOAD;
                        wr_addr_q     <= '0;
                        cfg_ready_q   <= 1'b1;
                        table_valid_q <= 1'b0;
                        in_ready_q    <= 1'b0;
                    end
                end
                default: begin
                    state_q       <= EMPTY;
                    wr_addr_q     <= '0;
                    cfg_ready_q   <= 1'b0;
                    table_valid_q <= 1'b0;
                    in_ready_q    <= 1'b0;
                end
            endcase
        end
    end

    // Result-valid flag tracks accepted lookups one cycle later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= rd_en_d;
        end
    end

    lut_neuron_table_mem #(
        .IN_BITS  (IN_BITS),
        .OUT_BITS (OUT_BITS)
    ) u_mem (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (wr_en_d),
        .wr_addr_i (wr_addr_q),
        .wr_data_i (cfg_data),
        .rd_en_i   (rd_en_d),
        .rd_addr_i (in_data),
        .rd_data_o (out_data)
`ifdef LUT_READBACK_EN
        ,
        .rb_addr_i (rb_addr),
        .rb_data_o (rb_data)
`endif
    );

    assign cfg_ready   = cfg_ready_q;
    assign load_done   = load_done_q;
    assign table_valid = table_valid_q;
    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;

endmodule

// File: tb/tb_lut_neuron_table_loader.sv
// Directed bench for lut_neuron_table_loader (readback checks when
// LUT_READBACK_EN is defined).
module tb_lut_neuron_table_loader;
    import lut_neuron_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       load_start;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [1:0] cfg_data;
    logic       load_done;
    logic       table_valid;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       out_valid;
    logic [1:0] out_data;
`ifdef LUT_READBACK_EN
    logic [3:0] rb_addr;
    logic [1:0] rb_data;
`endif

    int n_cmp;
    int n_err;
    int done_cnt;
    logic [1:0] exp_tbl [16];
    logic [1:0] pat_a   [16];

    lut_neuron_table_loader dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_start  (load_start),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_data    (cfg_data),
        .load_done   (load_done),
        .table_valid (table_valid),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_data    (out_data)
`ifdef LUT_READBACK_EN
        ,
        .rb_addr     (rb_addr),
        .rb_data     (rb_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".cfg_ready"},   32'(cfg_ready),   32'd0);
        check({tag, ".load_done"},   32'(load_done),   32'd0);
        check({tag, ".table_valid"}, 32'(table_valid), 32'd0);
        check({tag, ".in_ready"},    32'(in_ready),    32'd0);
        check({tag, ".out_valid"},   32'(out_valid),   32'd0);
        check({tag, ".out_data"},    32'(out_data),    32'd0);
        check({tag, ".state"},       32'(dut.state_q), 32'(EMPTY));
    endtask

    // Stream exp_tbl in address order with `gap` idle cycles between entries;
    // in_valid is held high so that no lookup may be accepted while loading.
    task automatic load_tbl(input int gap, output int dcnt);
        dcnt = 0;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        check("load.cfg_ready", 32'(cfg_ready), 32'd1);
        for (int i = 0; i < 16; i++) begin
            cfg_valid = 1'b1;
            cfg_data  = exp_tbl[i];
            in_valid  = 1'b1;
            in_data   = 4'(i);
            tick();
            if (load_done) dcnt++;
            check("load.wr_addr", 32'(dut.wr_addr_q), 32'((i + 1) % 16));
            check("load.no_out", 32'(out_valid), 32'd0);
            cfg_valid = 1'b0;
            for (int g = 0; g < gap; g++) begin
                tick();
                if (load_done) dcnt++;
                check("gap.wr_addr", 32'(dut.wr_addr_q), 32'((i + 1) % 16));
                check("gap.table_valid", 32'(table_valid), 32'(i == 15));
            end
        end
        in_valid = 1'b0;
        tick();
        if (load_done) dcnt++;
        check("load.table_valid", 32'(table_valid), 32'd1);
        check("load.in_ready",    32'(in_ready),    32'd1);
        check("load.cfg_ready",   32'(cfg_ready),   32'd0);
    endtask

    // Back-to-back lookups across every address
    task automatic lookup_all(input string tag);
        for (int a = 0; a < 16; a++) begin
            in_valid = 1'b1;
            in_data  = 4'(a);
            tick();
            check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
            check({tag, ".out_data"},  32'(out_data),  32'(exp_tbl[a]));
        end
        in_valid = 1'b0;
        tick();
        check({tag, ".idle_valid"}, 32'(out_valid), 32'd0);
        check({tag, ".hold_data"},  32'(out_data),  32'(exp_tbl[15]));
    endtask

`ifdef LUT_READBACK_EN
    task automatic readback_all(input string tag);
        for (int a = 0; a < 16; a++) begin
            rb_addr = 4'(a);
            #1;
            check({tag, ".rb_data"}, 32'(rb_data), 32'(exp_tbl[a]));
        end
    endtask
`endif

    initial begin
        n_cmp = 0;
        n_err = 0;
        pat_a = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd0, 2'd1, 2'd3, 2'd3,
                  2'd0, 2'd1, 2'd3, 2'd3, 2'd0, 2'd0, 2'd1, 2'd2};
        rst_n      = 1'b0;
        load_start = 1'b0;
        cfg_valid  = 1'b0;
        cfg_data   = 2'd0;
        in_valid   = 1'b0;
        in_data    = 4'd0;
`ifdef LUT_READBACK_EN
        rb_addr    = 4'd0;
`endif
        tick();
        tick();
        check_idle_outputs("reset");
        rst_n = 1'b1;
        tick();

        // Requests while EMPTY are ignored
        in_valid = 1'b1;
        in_data  = 4'd3;
        tick();
        check("empty.in_ready",  32'(in_ready),  32'd0);
        check("empty.out_valid", 32'(out_valid), 32'd0);
        in_valid = 1'b0;

        // First load of the reference pattern
        exp_tbl = pat_a;
        load_tbl(0, done_cnt);
        check("loadA.done_cnt", 32'(done_cnt), 32'd1);
        in_valid = 1'b1;
        in_data  = 4'b1111;
        tick();
        check("lkA.f.valid", 32'(out_valid), 32'd1);
        check("lkA.f.data",  32'(out_data),  32'd2);
        in_data = 4'b0101;
        tick();
        check("lkA.5.data",  32'(out_data),  32'd1);
        in_valid = 1'b0;
        tick();
        lookup_all("sweepA");
`ifdef LUT_READBACK_EN
        readback_all("rbA");
`endif

        // Reload from READY: the coincident request still sees the old table
        load_start = 1'b1;
        in_valid   = 1'b1;
        in_data    = 4'd15;
        tick();
        load_start = 1'b0;
        check("reld.old_valid",   32'(out_valid),   32'd1);
        check("reld.old_data",    32'(out_data),    32'd2);
        check("reld.table_valid", 32'(table_valid), 32'd0);
        check("reld.in_ready",    32'(in_ready),    32'd0);
        done_cnt = 0;
        for (int i = 0; i < 7; i++) begin
            cfg_valid = 1'b1;
            cfg_data  = 2'd3;
            tick();
            if (load_done) done_cnt++;
            check("part.no_out", 32'(out_valid), 32'd0);
        end
        check("part.wr_addr", 32'(dut.wr_addr_q), 32'd7);
        // Restart while an entry handshakes: entry discarded, address back to 0
        load_start = 1'b1;
        cfg_data   = 2'd2;
        tick();
        load_start = 1'b0;
        cfg_valid  = 1'b0;
        in_valid   = 1'b0;
        if (load_done) done_cnt++;
        check("restart.wr_addr",     32'(dut.wr_addr_q), 32'd0);
        check("restart.table_valid", 32'(table_valid),   32'd0);
        check("restart.cfg_ready",   32'(cfg_ready),     32'd1);
        for (int i = 0; i < 16; i++) exp_tbl[i] = 2'b01;
        for (int i = 0; i < 16; i++) begin
            cfg_valid = 1'b1;
            cfg_data  = 2'b01;
            tick();
            if (load_done) done_cnt++;
        end
        cfg_valid = 1'b0;
        tick();
        if (load_done) done_cnt++;
        check("restart.done_cnt", 32'(done_cnt),     32'd1);
        check("restart.tv",       32'(table_valid),  32'd1);
        lookup_all("sweepB");

        // Throttled config stream, one entry every third cycle
        for (int i = 0; i < 16; i++) exp_tbl[i] = 2'((i * 3 + 1) % 4);
        load_tbl(2, done_cnt);
        check("thr.done_cnt", 32'(done_cnt), 32'd1);
        lookup_all("sweepC");
`ifdef LUT_READBACK_EN
        readback_all("rbC");
`endif

        // Asynchronous reset in the middle of a load
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cfg_valid = 1'b1;
            cfg_data  = 2'd0;
            tick();
        end
        cfg_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("rstLoad");
        check("rstLoad.wr_addr", 32'(dut.wr_addr_q), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Reload, then reset while lookups are streaming
        exp_tbl = pat_a;
        load_tbl(0, done_cnt);
        check("loadD.done_cnt", 32'(done_cnt), 32'd1);
        in_valid = 1'b1;
        in_data  = 4'd15;
        tick();
        check("inf.data", 32'(out_data), 32'd2);
        in_data = 4'd0;
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("rstInf");
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        in_valid = 1'b1;
        tick();
        check("postrst.no_out", 32'(out_valid), 32'd0);
        in_valid = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Absolute time bound so the run always terminates
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
